// File: rtl/frv_fetch_realign_buffer_pkg.sv
// frv_fetch_realign_buffer_pkg: shared halfword type and compressed-opcode helpers
package frv_fetch_realign_buffer_pkg;
  typedef logic [15:0] halfword_t;
  localparam logic [1:0] OPC_32 = 2'b11;
  function automatic logic is_rvc(halfword_t h);
    return h[1:0] != OPC_32;
  endfunction
endpackage

// File: rtl/frv_fetch_realign_buffer.sv
// frv_fetch_realign_buffer: halfword shift buffer realigning fetch words into 16/32-bit instructions
module frv_fetch_realign_buffer
  import frv_fetch_realign_buffer_pkg::*;
#(
  parameter int BUF_HW = 4,
  parameter int XL = 31
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          flush,
  output logic          f_ready,
  input  logic          f_4byte,
  input  logic          f_2byte,
  input  logic          f_err,
  input  logic [XL:0]   f_in,
  output logic [2:0]    buf_depth,
  output logic [2:0]    n_buf_depth,
  output logic [XL:0]   buf_out,
  output logic          buf_16,
  output logic          buf_32,
  output logic          buf_out_2,
  output logic          buf_out_4,
  output logic          buf_err,
  output logic          buf_valid,
  input  logic          buf_ready
);
  halfword_t slot_q [BUF_HW];
  halfword_t slot_n [BUF_HW];
  halfword_t slot_x [BUF_HW+2];
  logic [BUF_HW-1:0] err_q, err_n;
  logic [BUF_HW+1:0] err_x;
  logic [1:0] pop, push;
  logic [3:0] base, raw;
  logic d1, d2;
  function automatic logic [1:0] pop_count(logic rvc, logic e0, logic [2:0] d);
    return (rvc || (e0 && d == 3'd1)) ? 2'd1 : 2'd2;
  endfunction
  assign d1 = buf_depth >= 3'd1;
  assign d2 = buf_depth >= 3'd2;
  assign buf_16 = is_rvc(slot_q[0]);
  assign buf_32 = !buf_16;
  assign buf_out = buf_16 ? {16'h0, slot_q[0]} : {slot_q[1], slot_q[0]};
  assign buf_out_2 = d1 && buf_16;
  assign buf_out_4 = d2 && buf_32;
  assign buf_err = err_q[0] || (buf_32 && d2 && err_q[1]);
  assign buf_valid = buf_out_2 || buf_out_4 || (d1 && err_q[0]);
  assign f_ready = buf_depth <= 3'(BUF_HW - 2);
  assign pop = (buf_valid && buf_ready) ? pop_count(buf_16, err_q[0], buf_depth) : 2'd0;
  assign push = f_4byte ? 2'd2 : f_2byte ? 2'd1 : 2'd0;
  assign base = {1'b0, buf_depth} - {2'b0, pop};
  assign raw = base + {2'b0, push};
  // excess halfwords beyond capacity are dropped
  assign n_buf_depth = flush ? 3'd0 : (raw > 4'(BUF_HW) ? 3'(BUF_HW) : raw[2:0]);
  always_comb begin
    slot_x = '{default: '0};
    for (int i = 0; i < BUF_HW; i++) slot_x[i] = slot_q[i];
    err_x = {2'b00, err_q};
  end
  for (genvar i = 0; i < BUF_HW; i++) begin : g_slot
    halfword_t sh;
    logic es, wr0, wr1;
    assign sh = pop == 2'd2 ? slot_x[i+2] : pop == 2'd1 ? slot_x[i+1] : slot_x[i];
    assign es = pop == 2'd2 ? err_x[i+2] : pop == 2'd1 ? err_x[i+1] : err_x[i];
    assign wr0 = push != 2'd0 && base == 4'(i);
    assign wr1 = f_4byte && base + 4'd1 == 4'(i);
    assign slot_n[i] = wr0 ? (f_4byte ? f_in[15:0] : f_in[31:16]) : wr1 ? f_in[31:16] : sh;
    assign err_n[i] = (4'(i) < {1'b0, n_buf_depth}) && ((wr0 || wr1) ? f_err : es);
  end
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      buf_depth <= 3'd0;
      slot_q <= '{default: '0};
      err_q <= '0;
    end else begin
      buf_depth <= n_buf_depth;
      slot_q <= slot_n;
      err_q <= err_n;
    end
  end
  always_ff @(posedge g_clk) begin
    if (!g_reset && !flush) begin
      assert (!(f_4byte && f_2byte));
      assert (raw <= 4'(BUF_HW));
    end
  end
endmodule

// File: tb/tb_frv_fetch_realign_buffer.sv
// tb_frv_fetch_realign_buffer: directed vectors for the fetch realignment buffer
module tb_frv_fetch_realign_buffer;
  logic g_clk = 0, g_reset = 1, flush = 0, f_4byte = 0, f_2byte = 0, f_err = 0, buf_ready = 0;
  logic [31:0] f_in = '0;
  logic f_ready, buf_16, buf_32, buf_out_2, buf_out_4, buf_err, buf_valid;
  logic [2:0] buf_depth, n_buf_depth;
  logic [31:0] buf_out;
  int vectors = 0, miscompares = 0;
  frv_fetch_realign_buffer dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .f_ready(f_ready),
    .f_4byte(f_4byte), .f_2byte(f_2byte), .f_err(f_err), .f_in(f_in),
    .buf_depth(buf_depth), .n_buf_depth(n_buf_depth), .buf_out(buf_out),
    .buf_16(buf_16), .buf_32(buf_32), .buf_out_2(buf_out_2), .buf_out_4(buf_out_4),
    .buf_err(buf_err), .buf_valid(buf_valid), .buf_ready(buf_ready)
  );
  always #5 g_clk = ~g_clk;
  task automatic cyc;
    @(posedge g_clk);
    #1;
    {flush, f_4byte, f_2byte, f_err, buf_ready} = '0;
  endtask
  task automatic test_reset;
    #1;
    vectors++; if (buf_depth !== 3'd0) begin miscompares++; $display("FAIL rst_depth got %0d exp 0", buf_depth); end
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", buf_valid); end
    vectors++; if (buf_out !== 32'h0) begin miscompares++; $display("FAIL rst_out got %h exp 0", buf_out); end
    vectors++; if (f_ready !== 1'b1) begin miscompares++; $display("FAIL rst_fready got %b exp 1", f_ready); end
    vectors++; if ({buf_err, buf_out_2, buf_out_4} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b exp 000", {buf_err, buf_out_2, buf_out_4}); end
    cyc(); cyc();
    g_reset = 0;
    cyc();
  endtask
  task automatic test_rvc_pair;
    f_4byte = 1; f_in = 32'h0001_4501; cyc();
    vectors++; if (buf_depth !== 3'd2) begin miscompares++; $display("FAIL t1_depth got %0d exp 2", buf_depth); end
    vectors++; if (buf_16 !== 1'b1 || buf_out_2 !== 1'b1) begin miscompares++; $display("FAIL t1_b16 got %b%b exp 11", buf_16, buf_out_2); end
    vectors++; if (buf_out !== 32'h0000_4501) begin miscompares++; $display("FAIL t1_out0 got %h exp 00004501", buf_out); end
    buf_ready = 1; #1;
    vectors++; if (n_buf_depth !== 3'd1) begin miscompares++; $display("FAIL t1_ndepth got %0d exp 1", n_buf_depth); end
    cyc();
    vectors++; if (buf_out !== 32'h0000_0001) begin miscompares++; $display("FAIL t1_out1 got %h exp 00000001", buf_out); end
    vectors++; if (buf_depth !== 3'd1) begin miscompares++; $display("FAIL t1_depth1 got %0d exp 1", buf_depth); end
    buf_ready = 1; cyc();
    vectors++; if (buf_depth !== 3'd0 || buf_valid !== 1'b0) begin miscompares++; $display("FAIL t1_drain got %0d/%b exp 0/0", buf_depth, buf_valid); end
  endtask
  task automatic test_rv32;
    f_4byte = 1; f_in = 32'h0000_0513; cyc();
    vectors++; if (buf_32 !== 1'b1 || buf_valid !== 1'b1 || buf_out_4 !== 1'b1) begin miscompares++; $display("FAIL t2_flags got %b%b%b exp 111", buf_32, buf_valid, buf_out_4); end
    vectors++; if (buf_out !== 32'h0000_0513) begin miscompares++; $display("FAIL t2_out got %h exp 00000513", buf_out); end
    buf_ready = 1; #1;
    vectors++; if (n_buf_depth !== 3'd0) begin miscompares++; $display("FAIL t2_ndepth got %0d exp 0", n_buf_depth); end
    cyc();
    vectors++; if (buf_depth !== 3'd0 || f_ready !== 1'b1) begin miscompares++; $display("FAIL t2_empty got %0d/%b exp 0/1", buf_depth, f_ready); end
  endtask
  task automatic test_split_and_back_to_back;
    f_2byte = 1; f_in = 32'h0513_1234; cyc();
    vectors++; if (buf_depth !== 3'd1 || buf_valid !== 1'b0) begin miscompares++; $display("FAIL t3_half got %0d/%b exp 1/0", buf_depth, buf_valid); end
    buf_ready = 1; #1;
    vectors++; if (n_buf_depth !== 3'd1) begin miscompares++; $display("FAIL t3_ignore_ready got %0d exp 1", n_buf_depth); end
    buf_ready = 0;
    f_4byte = 1; f_in = 32'hABCD_0000; cyc();
    vectors++; if (buf_out !== 32'h0000_0513 || buf_depth !== 3'd3) begin miscompares++; $display("FAIL t3_join got %h/%0d exp 00000513/3", buf_out, buf_depth); end
    buf_ready = 1; f_4byte = 1; f_in = 32'h1111_2222; #1;
    vectors++; if (n_buf_depth !== 3'd3) begin miscompares++; $display("FAIL t4_ndepth got %0d exp 3", n_buf_depth); end
    cyc();
    vectors++; if (buf_out !== 32'h0000_ABCD || buf_depth !== 3'd3) begin miscompares++; $display("FAIL t4_h0 got %h/%0d exp 0000abcd/3", buf_out, buf_depth); end
    buf_ready = 1; cyc();
    vectors++; if (buf_out !== 32'h0000_2222 || buf_depth !== 3'd2) begin miscompares++; $display("FAIL t4_h1 got %h/%0d exp 00002222/2", buf_out, buf_depth); end
    buf_ready = 1; cyc();
    vectors++; if (buf_out !== 32'h0000_1111 || buf_depth !== 3'd1) begin miscompares++; $display("FAIL t4_h2 got %h/%0d exp 00001111/1", buf_out, buf_depth); end
    buf_ready = 1; cyc();
    vectors++; if (buf_depth !== 3'd0) begin miscompares++; $display("FAIL t4_drain got %0d exp 0", buf_depth); end
  endtask
  task automatic test_errors;
    f_2byte = 1; f_err = 1; f_in = 32'h0003_0000; cyc();
    vectors++; if (buf_valid !== 1'b1 || buf_err !== 1'b1 || buf_32 !== 1'b1) begin miscompares++; $display("FAIL t5_err_lo got %b%b%b exp 111", buf_valid, buf_err, buf_32); end
    vectors++; if (buf_out[15:0] !== 16'h0003) begin miscompares++; $display("FAIL t5_out got %h exp 0003", buf_out[15:0]); end
    buf_ready = 1; #1;
    vectors++; if (n_buf_depth !== 3'd0) begin miscompares++; $display("FAIL t5_pop1 got %0d exp 0", n_buf_depth); end
    cyc();
    vectors++; if (buf_valid !== 1'b0 || buf_err !== 1'b0) begin miscompares++; $display("FAIL t5_clear got %b%b exp 00", buf_valid, buf_err); end
    f_4byte = 1; f_err = 1; f_in = 32'h5555_0003; cyc();
    vectors++; if (buf_out !== 32'h5555_0003 || buf_err !== 1'b1 || buf_depth !== 3'd2) begin miscompares++; $display("FAIL t5_err4 got %h/%b/%0d exp 55550003/1/2", buf_out, buf_err, buf_depth); end
    buf_ready = 1; #1;
    vectors++; if (n_buf_depth !== 3'd0) begin miscompares++; $display("FAIL t5_pop2 got %0d exp 0", n_buf_depth); end
    cyc();
    f_2byte = 1; f_in = 32'h0003_0000; cyc();
    vectors++; if (buf_valid !== 1'b0 || buf_err !== 1'b0) begin miscompares++; $display("FAIL t5_clean_lo got %b%b exp 00", buf_valid, buf_err); end
    f_2byte = 1; f_err = 1; f_in = 32'h7777_0000; cyc();
    vectors++; if (buf_err !== 1'b1 || buf_valid !== 1'b1 || buf_out !== 32'h7777_0003) begin miscompares++; $display("FAIL t5_err_hi got %b%b/%h exp 11/77770003", buf_err, buf_valid, buf_out); end
    buf_ready = 1; cyc();
    vectors++; if (buf_depth !== 3'd0) begin miscompares++; $display("FAIL t5_drain got %0d exp 0", buf_depth); end
  endtask
  task automatic test_flush_and_async_reset;
    f_4byte = 1; f_in = 32'h0001_0001; cyc();
    f_4byte = 1; f_in = 32'h0002_0002; cyc();
    vectors++; if (buf_depth !== 3'd4 || f_ready !== 1'b0) begin miscompares++; $display("FAIL t6_full got %0d/%b exp 4/0", buf_depth, f_ready); end
    flush = 1; f_4byte = 1; buf_ready = 1; f_in = 32'h0003_0003; #1;
    vectors++; if (n_buf_depth !== 3'd0) begin miscompares++; $display("FAIL t6_nflush got %0d exp 0", n_buf_depth); end
    cyc();
    vectors++; if (buf_depth !== 3'd0 || buf_valid !== 1'b0) begin miscompares++; $display("FAIL t6_flush got %0d/%b exp 0/0", buf_depth, buf_valid); end
    f_4byte = 1; f_in = 32'h0001_0001; cyc();
    f_4byte = 1; f_in = 32'h0002_0002; cyc();
    #2 g_reset = 1; #1;
    vectors++; if (buf_depth !== 3'd0 || buf_valid !== 1'b0 || f_ready !== 1'b1) begin miscompares++; $display("FAIL t6_arst got %0d/%b/%b exp 0/0/1", buf_depth, buf_valid, f_ready); end
    vectors++; if (buf_out !== 32'h0 || {buf_err, buf_out_2, buf_out_4} !== 3'b000) begin miscompares++; $display("FAIL t6_arst_out got %h/%b exp 0/000", buf_out, {buf_err, buf_out_2, buf_out_4}); end
    cyc();
    g_reset = 0;
    cyc();
    vectors++; if (buf_depth !== 3'd0) begin miscompares++; $display("FAIL t6_post got %0d exp 0", buf_depth); end
  endtask
  initial begin
    test_reset();
    test_rvc_pair();
    test_rv32();
    test_split_and_back_to_back();
    test_errors();
    test_flush_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frv_fetch_realign_buffer.md
Name: frv_fetch_realign_buffer

Overview:
- Halfword-granular realignment buffer between the instruction memory response path and the decode stage.
- Accepts 4-byte fetch responses, or only the upper halfword when fetch is halfword-misaligned.
- Presents one complete 16-bit (compressed) or 32-bit instruction to decode, with its error flag.
- Pops 1 or 2 halfwords per accepted instruction and supports same-cycle push, pop and flush.

Parameters:
- BUF_HW, 4, buffer capacity in halfwords (legal values 3..7; depth counter is 3 bits).
- XL, 31, MSB index of the data word (from the common core header).

Ports:
- g_clk  in  1  global clock, rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered halfwords.
- f_ready  out  1  at least 2 free halfword slots (depth <= BUF_HW-2).
- f_4byte  in  1  push f_in[15:0] then f_in[31:16].
- f_2byte  in  1  push f_in[31:16] only.
- f_err  in  1  error tag applied to every halfword pushed this cycle.
- f_in  in  32  fetched word.
- buf_depth  out  3  current halfword count.
- n_buf_depth  out  3  next-cycle halfword count (combinational).
- buf_out  out  32  instruction; upper 16 bits are zero when buf_16.
- buf_16  out  1  slot0[1:0] != 2'b11; only meaningful when depth >= 1.
- buf_32  out  1  slot0[1:0] == 2'b11; only meaningful when depth >= 1.
- buf_out_2  out  1  depth >= 1 && buf_16.
- buf_out_4  out  1  depth >= 2 && buf_32.
- buf_err  out  1  error tag of the presented instruction.
- buf_valid  out  1  complete instruction or error available.
- buf_ready  in  1  consumer takes the presented instruction this cycle.

Behaviour:
- Storage: BUF_HW halfword slots plus one error bit per slot. Slot0 is always the oldest halfword; the buffer is a shift structure, so no pointers wrap.
- Reset (async): depth=0. All slot data and error bits are 0. Outputs are therefore buf_valid=0, buf_out=0, buf_err=0, f_ready=1, buf_out_2=0, buf_out_4=0.
- buf_err = err0 | (buf_32 & depth>=2 & err1).
- buf_valid = buf_out_2 | buf_out_4 | (depth>=1 & err0). A 32-bit instruction whose low half is erroneous is presented immediately, without waiting for its upper half.
- Pop amount, taken only when buf_valid & buf_ready:
  - 1 halfword if buf_16, or if err0 & depth==1.
  - 2 halfwords otherwise.
  - 0 when buf_ready is asserted without buf_valid (ignored).
- Push amount: f_4byte pushes 2 halfwords, f_2byte pushes 1. If both are asserted, f_4byte wins; this is an assertion failure.
- Push in same cycle as pop: the pop is applied first. New halfwords are written at index (depth - pop). n_buf_depth = depth - pop + push.
- Overflow: a push while f_ready=0 is illegal. It is an assertion failure; RTL saturates by dropping the excess halfwords and depth never exceeds BUF_HW. Upstream only issues a request when f_ready is projected.
- flush has priority over push and pop in the same cycle: n_buf_depth=0 and data pushed that cycle is discarded. Error bits clear on flush.
- Slots at index >= depth are don't-care, except that err bits beyond depth are forced to 0.
- No combinational path from buf_ready to f_ready or buf_valid. n_buf_depth does depend combinationally on buf_ready.
- Latency: data pushed at edge N is visible on buf_out after edge N, i.e. one cycle.

Decomposition:
- Shared package/header holds:
  - halfword type (16 bits).
  - constant OPC_32 = 2'b11.
  - function is_rvc(halfword).
- No sub-module is needed. One local function computes the pop count; a generate loop builds the per-slot shift/write muxes.

Test Plan:
1. Reset, then f_4byte with f_in=32'h0001_4501 (two RVC halfwords) → next cycle depth=2, buf_16=1, buf_out=32'h0000_4501. Pop → buf_out=32'h0000_0001, depth=1.
2. f_4byte f_in=32'h0000_0513 (addi, 32-bit) → buf_32=1, buf_valid=1, buf_out=32'h0000_0513. Pop 2 → depth=0, f_ready=1.
3. f_2byte f_in=32'h0513_xxxx → depth=1, buf_valid=0 (32-bit half only). Then f_4byte f_in=32'hABCD_0000 → buf_out=32'h0000_0513, depth=3.
4. depth=3, pop of 32-bit with simultaneous f_4byte → n_buf_depth=3, FIFO ordering of halfwords preserved.
5. f_4byte with f_err=1, low halfword 16'h0003 (32-bit opcode) → buf_valid=1, buf_err=1 when depth=1 on f_2byte variant. Pop removes 1 halfword.
6. depth=4, assert flush together with f_4byte and buf_ready → depth=0, buf_valid=0 next cycle. Assert g_reset mid-stream → all outputs at reset values without a clock edge.
